bp_be_dcache_issue_arbiter: RTL and testbench

- Shares one bp_be_dcache pipeline between two requesters: lane 0 is the LSU and lane 1 is the page-table walker.
- Each lane's request is held in a one-entry buffer until the dcache completes it.
- The block drives the dcache issue, TL-stage ptag/uncached and poison inputs.
- It replays missed operations and routes results back to the owning lane.
- It sits between the BE issue logic and the dcache instance, and replaces ad-hoc rollback queues in test harnesses.

---
 rtl/bp_be_dcache_pkg.sv | 38 +++
 rtl/bp_be_dcache_arb_entry.sv | 60 ++++++
 rtl/bp_be_dcache_issue_arbiter.sv | 147 ++++++++++++++
 tb/tb_bp_be_dcache_issue_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_dcache_pkg.sv
// rtl/bp_be_dcache_pkg.sv - lane enum, widths, round-robin helper and holding-entry struct macro
`ifndef BP_BE_DCACHE_PKG_SV
`define BP_BE_DCACHE_PKG_SV

package bp_be_dcache_pkg;

    localparam int bp_page_offset_width_gp = 12;
    localparam int dcache_opcode_width_gp  = 5;

    typedef enum logic {
        e_lane_lsu = 1'b0,
        e_lane_ptw = 1'b1
    } bp_be_dcache_lane_e;

    // Preferred lane wins when eligible, otherwise the other lane.
    function automatic bp_be_dcache_lane_e rr_pick(input logic [1:0] eligible,
                                                   input bp_be_dcache_lane_e ptr);
        if (eligible[ptr]) begin
            return ptr;
        end
        return (ptr == e_lane_lsu) ? e_lane_ptw : e_lane_lsu;
    endfunction

endpackage

`define BP_BE_DCACHE_PKT_WIDTH(page_offset_width_mp, dword_width_mp) \
    (bp_be_dcache_pkg::dcache_opcode_width_gp + (page_offset_width_mp) + (dword_width_mp))

`define DECLARE_BP_BE_DCACHE_ARB_ENTRY_S(page_offset_width_mp, dword_width_mp, ptag_width_mp) \
    typedef struct packed { \
        logic v; \
        logic inflight; \
        logic [`BP_BE_DCACHE_PKT_WIDTH(page_offset_width_mp, dword_width_mp)-1:0] pkt; \
        logic [(ptag_width_mp)-1:0] ptag; \
        logic uncached; \
    } bp_be_dcache_arb_entry_s

`endif

// File: rtl/bp_be_dcache_arb_entry.sv
// rtl/bp_be_dcache_arb_entry.sv - one-entry request holding register with valid/inflight tracking
module bp_be_dcache_arb_entry
    import bp_be_dcache_pkg::*;
#(
    parameter int page_offset_width_p = bp_page_offset_width_gp,
    parameter int dword_width_p       = 64,
    parameter int ptag_width_p        = 28,
    localparam int pkt_width_lp       = `BP_BE_DCACHE_PKT_WIDTH(page_offset_width_p, dword_width_p)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_v,
    input  logic [pkt_width_lp-1:0] load_pkt,
    input  logic [ptag_width_p-1:0] load_ptag,
    input  logic                    load_uncached,
    input  logic                    set_inflight,
    input  logic                    clear_inflight,
    input  logic                    clear_valid,
    output logic                    v,
    output logic                    inflight,
    output logic [pkt_width_lp-1:0] pkt,
    output logic [ptag_width_p-1:0] ptag,
    output logic                    uncached
);

    `DECLARE_BP_BE_DCACHE_ARB_ENTRY_S(page_offset_width_p, dword_width_p, ptag_width_p);

    bp_be_dcache_arb_entry_s entry_r;

    // Capture only into an empty entry; completion takes precedence over any inflight update.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_r <= '0;
        end else begin
            if (load_v && !entry_r.v) begin
                entry_r.v        <= 1'b1;
                entry_r.pkt      <= load_pkt;
                entry_r.ptag     <= load_ptag;
                entry_r.uncached <= load_uncached;
            end
            if (set_inflight) begin
                entry_r.inflight <= 1'b1;
            end
            if (clear_inflight) begin
                entry_r.inflight <= 1'b0;
            end
            if (clear_valid) begin
                entry_r.v        <= 1'b0;
                entry_r.inflight <= 1'b0;
            end
        end
    end

    assign v        = entry_r.v;
    assign inflight = entry_r.inflight;
    assign pkt      = entry_r.pkt;
    assign ptag     = entry_r.ptag;
    assign uncached = entry_r.uncached;

endmodule

// File: rtl/bp_be_dcache_issue_arbiter.sv
// rtl/bp_be_dcache_issue_arbiter.sv - shares one dcache pipeline between LSU and PTW with miss replay
// Define BP_BE_DCACHE_ARB_FIXED_PRIO_EN to give the PTW lane strict priority instead of round-robin.
module bp_be_dcache_issue_arbiter
    import bp_be_dcache_pkg::*;
#(
    parameter int page_offset_width_p  = bp_page_offset_width_gp,
    parameter int dword_width_p        = 64,
    parameter int paddr_width_p        = 40,
    localparam int dcache_pkt_width_lp = `BP_BE_DCACHE_PKT_WIDTH(page_offset_width_p, dword_width_p),
    localparam int ptag_width_lp       = paddr_width_p - bp_page_offset_width_gp
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [2*dcache_pkt_width_lp-1:0] req_pkt_i,
    input  logic [2*ptag_width_lp-1:0]     req_ptag_i,
    input  logic [1:0]                     req_uncached_i,
    input  logic [1:0]                     req_v_i,
    output logic [1:0]                     req_ready_o,
    output logic [dword_width_p-1:0]       resp_data_o,
    output logic [1:0]                     resp_v_o,
    output logic [dcache_pkt_width_lp-1:0] dc_pkt_o,
    output logic                           dc_v_o,
    input  logic                           dc_ready_i,
    output logic [ptag_width_lp-1:0]       dc_ptag_o,
    output logic                           dc_uncached_o,
    output logic                           dc_poison_o,
    input  logic [dword_width_p-1:0]       dc_data_i,
    input  logic                           dc_v_i
);

    logic [1:0]                     ent_v;
    logic [1:0]                     ent_inflight;
    logic [1:0]                     ent_uncached;
    logic [dcache_pkt_width_lp-1:0] ent_pkt  [2];
    logic [ptag_width_lp-1:0]       ent_ptag [2];

    logic [1:0] set_inflight;
    logic [1:0] clear_inflight;
    logic [1:0] clear_valid;
    logic [1:0] eligible;

    logic               tl_v;
    logic               dm_v;
    bp_be_dcache_lane_e tl_owner;
    bp_be_dcache_lane_e dm_owner;
    bp_be_dcache_lane_e grant;

    logic miss_now;
    logic hit_now;
    logic issue;

    for (genvar n = 0; n < 2; n++) begin : lane
        bp_be_dcache_arb_entry #(
            .page_offset_width_p(page_offset_width_p),
            .dword_width_p      (dword_width_p),
            .ptag_width_p       (ptag_width_lp)
        ) entry (
            .clk           (clk_i),
            .reset         (reset_i),
            .load_v        (req_v_i[n]),
            .load_pkt      (req_pkt_i[n*dcache_pkt_width_lp +: dcache_pkt_width_lp]),
            .load_ptag     (req_ptag_i[n*ptag_width_lp +: ptag_width_lp]),
            .load_uncached (req_uncached_i[n]),
            .set_inflight  (set_inflight[n]),
            .clear_inflight(clear_inflight[n]),
            .clear_valid   (clear_valid[n]),
            .v             (ent_v[n]),
            .inflight      (ent_inflight[n]),
            .pkt           (ent_pkt[n]),
            .ptag          (ent_ptag[n]),
            .uncached      (ent_uncached[n])
        );
    end

    assign eligible = ent_v & ~ent_inflight;
    assign miss_now = dm_v & ~dc_v_i;
    assign hit_now  = dm_v & dc_v_i;
    // A miss owns the cycle: the dcache is being poisoned, so nothing new enters.
    assign issue    = ~reset_i & dc_ready_i & (|eligible) & ~miss_now;

`ifdef BP_BE_DCACHE_ARB_FIXED_PRIO_EN
    assign grant = eligible[e_lane_ptw] ? e_lane_ptw : e_lane_lsu;
`else
    bp_be_dcache_lane_e rr_ptr_r;

    assign grant = rr_pick(eligible, rr_ptr_r);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr_r <= e_lane_lsu;
        end else if (issue) begin
            rr_ptr_r <= (grant == e_lane_lsu) ? e_lane_ptw : e_lane_lsu;
        end
    end
`endif

    always_comb begin
        set_inflight   = 2'b00;
        clear_inflight = 2'b00;
        clear_valid    = 2'b00;
        if (issue) begin
            set_inflight[grant] = 1'b1;
        end
        // Both the missing op and the op behind it in TL must be replayed.
        if (miss_now) begin
            clear_inflight[dm_owner] = 1'b1;
            if (tl_v) begin
                clear_inflight[tl_owner] = 1'b1;
            end
        end
        if (hit_now) begin
            clear_valid[dm_owner] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tl_v     <= 1'b0;
            dm_v     <= 1'b0;
            tl_owner <= e_lane_lsu;
            dm_owner <= e_lane_lsu;
        end else begin
            tl_v     <= issue;
            dm_v     <= tl_v & ~miss_now;
            dm_owner <= tl_owner;
            if (issue) begin
                tl_owner <= grant;
            end
        end
    end

    always_comb begin
        resp_v_o = 2'b00;
        if (hit_now && !reset_i) begin
            resp_v_o[dm_owner] = 1'b1;
        end
    end

    assign req_ready_o   = ~ent_v;
    assign resp_data_o   = dc_data_i;
    assign dc_v_o        = issue;
    assign dc_pkt_o      = ent_pkt[grant];
    assign dc_ptag_o     = tl_v ? ent_ptag[tl_owner] : '0;
    assign dc_uncached_o = tl_v & ent_uncached[tl_owner];
    assign dc_poison_o   = miss_now & ~reset_i;

endmodule

// File: tb/tb_bp_be_dcache_issue_arbiter.sv
// tb/tb_bp_be_dcache_issue_arbiter.sv - scoreboard bench for the dcache issue arbiter with a dcache pipe model
module tb_bp_be_dcache_issue_arbiter;
    import bp_be_dcache_pkg::*;

    localparam int pow = bp_page_offset_width_gp;
    localparam int dw  = 64;
    localparam int paw = 40;
    localparam int ptw = paw - pow;
    localparam int pkw = `BP_BE_DCACHE_PKT_WIDTH(pow, dw);

`ifdef BP_BE_DCACHE_ARB_FIXED_PRIO_EN
    localparam logic first_lane = 1'b1;
`else
    localparam logic first_lane = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_i;
    logic [2*pkw-1:0] req_pkt_i;
    logic [2*ptw-1:0] req_ptag_i;
    logic [1:0]       req_uncached_i;
    logic [1:0]       req_v_i;
    logic [1:0]       req_ready_o;
    logic [dw-1:0]    resp_data_o;
    logic [1:0]       resp_v_o;
    logic [pkw-1:0]   dc_pkt_o;
    logic             dc_v_o;
    logic             dc_ready_i;
    logic [ptw-1:0]   dc_ptag_o;
    logic             dc_uncached_o;
    logic             dc_poison_o;
    logic [dw-1:0]    dc_data_i;
    logic             dc_v_i;

    always #5 clk = ~clk;

    bp_be_dcache_issue_arbiter dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .req_pkt_i     (req_pkt_i),
        .req_ptag_i    (req_ptag_i),
        .req_uncached_i(req_uncached_i),
        .req_v_i       (req_v_i),
        .req_ready_o   (req_ready_o),
        .resp_data_o   (resp_data_o),
        .resp_v_o      (resp_v_o),
        .dc_pkt_o      (dc_pkt_o),
        .dc_v_o        (dc_v_o),
        .dc_ready_i    (dc_ready_i),
        .dc_ptag_o     (dc_ptag_o),
        .dc_uncached_o (dc_uncached_o),
        .dc_poison_o   (dc_poison_o),
        .dc_data_i     (dc_data_i),
        .dc_v_i        (dc_v_i)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [ptw-1:0] ptag_tab [256];
    logic [63:0]    data_tab [256];
    logic           unc_tab  [256];
    logic [7:0]     next_seq = 8'd1;

    logic [7:0]  send_q0 [$];
    logic [7:0]  send_q1 [$];
    logic [63:0] exp_q0  [$];
    logic [63:0] exp_q1  [$];
    logic        grant_log [$];

    logic       m_tl_v, m_dm_v, m_tl_lane, m_dm_lane;
    logic [7:0] m_tl_seq, m_dm_seq;
    logic       miss_armed;
    logic [7:0] miss_seq;
    int n_issue = 0, n_poison = 0, n_resp0 = 0, n_resp1 = 0;

    logic        s_dc_v;
    logic [1:0]  s_ready, s_resp_v;
    logic [63:0] s_resp_data;
    logic [ptw-1:0] s_ptag;

    function automatic logic [pkw-1:0] mk_pkt(input logic lane, input logic [7:0] seq);
        return {5'd2, 12'h080, 55'd0, lane, seq};
    endfunction

    task automatic new_op(input logic lane, input logic [ptw-1:0] ptag, input logic [63:0] data, input logic unc);
        ptag_tab[next_seq] = ptag;
        data_tab[next_seq] = data;
        unc_tab[next_seq]  = unc;
        if (lane) send_q1.push_back(next_seq);
        else      send_q0.push_back(next_seq);
        next_seq++;
    endtask

    task automatic apply_reset();
        reset_i = 1'b1;
        req_v_i = 2'b00; req_pkt_i = '0; req_ptag_i = '0; req_uncached_i = 2'b00;
        dc_v_i = 1'b0; dc_data_i = '0; dc_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        m_tl_v = 1'b0; m_dm_v = 1'b0; m_tl_lane = 1'b0; m_dm_lane = 1'b0;
        m_tl_seq = 8'd0; m_dm_seq = 8'd0; miss_armed = 1'b0; miss_seq = 8'd0;
        send_q0.delete(); send_q1.delete(); exp_q0.delete(); exp_q1.delete();
    endtask

    // One cycle: drive lanes and dcache response at negedge, check at +1, advance the dcache model at posedge.
    task automatic tick();
        logic hit, issued, poison_now, iss_lane;
        logic [7:0] iss_seq, s;
        logic [1:0] exp_resp, hs;
        logic [63:0] exp_data;
        logic [ptw-1:0] exp_ptag;
        logic exp_unc;
        req_v_i = 2'b00;
        if (send_q0.size() > 0) begin
            s = send_q0[0];
            req_v_i[0] = 1'b1;
            req_pkt_i[0 +: pkw] = mk_pkt(1'b0, s);
            req_ptag_i[0 +: ptw] = ptag_tab[s];
            req_uncached_i[0] = unc_tab[s];
        end
        if (send_q1.size() > 0) begin
            s = send_q1[0];
            req_v_i[1] = 1'b1;
            req_pkt_i[pkw +: pkw] = mk_pkt(1'b1, s);
            req_ptag_i[ptw +: ptw] = ptag_tab[s];
            req_uncached_i[1] = unc_tab[s];
        end
        hit = 1'b0;
        if (m_dm_v) begin
            hit = !(miss_armed && m_dm_seq == miss_seq);
            if (!hit) miss_armed = 1'b0;
        end
        dc_v_i = hit;
        dc_data_i = hit ? data_tab[m_dm_seq] : 64'h0;
        #1;
        s_dc_v = dc_v_o; s_ready = req_ready_o; s_resp_v = resp_v_o;
        s_resp_data = resp_data_o; s_ptag = dc_ptag_o;
        poison_now = m_dm_v & ~hit;
        n_cmp++;
        if (dc_poison_o !== poison_now) begin
            n_err++; $display("FAIL poison: got %b expected %b at %0t", dc_poison_o, poison_now, $time);
        end
        exp_resp = hit ? (m_dm_lane ? 2'b10 : 2'b01) : 2'b00;
        n_cmp++;
        if (resp_v_o !== exp_resp) begin
            n_err++; $display("FAIL resp_v: got %b expected %b at %0t", resp_v_o, exp_resp, $time);
        end else if (hit) begin
            n_cmp++;
            if ((m_dm_lane ? exp_q1.size() : exp_q0.size()) == 0) begin
                n_err++; $display("FAIL resp_unexpected: lane %0d got resp with nothing pending", m_dm_lane);
            end else begin
                if (m_dm_lane) begin exp_data = exp_q1.pop_front(); n_resp1++; end
                else           begin exp_data = exp_q0.pop_front(); n_resp0++; end
                if (resp_data_o !== exp_data) begin
                    n_err++; $display("FAIL resp_data: got %h expected %h", resp_data_o, exp_data);
                end
            end
        end
        exp_ptag = m_tl_v ? ptag_tab[m_tl_seq] : '0;
        exp_unc  = m_tl_v & unc_tab[m_tl_seq];
        n_cmp++;
        if (dc_ptag_o !== exp_ptag) begin
            n_err++; $display("FAIL tl_ptag: got %h expected %h", dc_ptag_o, exp_ptag);
        end
        n_cmp++;
        if (dc_uncached_o !== exp_unc) begin
            n_err++; $display("FAIL tl_uncached: got %b expected %b", dc_uncached_o, exp_unc);
        end
        n_cmp++;
        if (dc_v_o !== 1'b0 && (dc_ready_i !== 1'b1 || poison_now)) begin
            n_err++; $display("FAIL issue_blocked: dc_v_o %b ready %b miss %b", dc_v_o, dc_ready_i, poison_now);
        end
        issued   = dc_v_o & dc_ready_i;
        iss_seq  = dc_pkt_o[7:0];
        iss_lane = dc_pkt_o[8];
        if (issued) begin
            n_issue++;
            grant_log.push_back(iss_lane);
            n_cmp++;
            if ((m_tl_v && m_tl_lane == iss_lane) || (m_dm_v && m_dm_lane == iss_lane)) begin
                n_err++; $display("FAIL dup_issue: lane %0d issued while its op is in flight", iss_lane);
            end
        end
        hs = req_v_i & req_ready_o;
        if (hs[0]) exp_q0.push_back(data_tab[send_q0.pop_front()]);
        if (hs[1]) exp_q1.push_back(data_tab[send_q1.pop_front()]);
        if (poison_now) n_poison++;
        @(posedge clk);
        m_dm_v = m_tl_v & ~poison_now; m_dm_seq = m_tl_seq; m_dm_lane = m_tl_lane;
        m_tl_v = issued; m_tl_seq = iss_seq; m_tl_lane = iss_lane;
        @(negedge clk);
    endtask

    task automatic drain(input int max_cycles);
        int c = 0;
        while ((send_q0.size() > 0 || send_q1.size() > 0 || exp_q0.size() > 0 || exp_q1.size() > 0
                || m_tl_v || m_dm_v) && c < max_cycles) begin
            tick();
            c++;
        end
        n_cmp++;
        if (c >= max_cycles) begin
            n_err++; $display("FAIL drain_timeout: %0d cycles, pending %0d/%0d", c, exp_q0.size(), exp_q1.size());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_cmp++; if (req_ready_o !== 2'b11) begin n_err++; $display("FAIL rst_ready: got %b expected 11", req_ready_o); end
        n_cmp++; if (dc_v_o !== 1'b0) begin n_err++; $display("FAIL rst_dc_v: got %b expected 0", dc_v_o); end
        n_cmp++; if (dc_poison_o !== 1'b0) begin n_err++; $display("FAIL rst_poison: got %b expected 0", dc_poison_o); end
        n_cmp++; if (resp_v_o !== 2'b00) begin n_err++; $display("FAIL rst_resp_v: got %b expected 00", resp_v_o); end
        n_cmp++; if (dc_ptag_o !== '0) begin n_err++; $display("FAIL rst_ptag: got %h expected 0", dc_ptag_o); end
        n_cmp++; if (dc_uncached_o !== 1'b0) begin n_err++; $display("FAIL rst_uncached: got %b expected 0", dc_uncached_o); end
        @(negedge clk);
    endtask

    task automatic test_single_hit();
        apply_reset();
        new_op(1'b0, 28'h80000, 64'hDEADBEEF, 1'b0);
        tick();
        n_cmp++; if (s_ready[0] !== 1'b1) begin n_err++; $display("FAIL c0_ready: got %b expected 1", s_ready[0]); end
        tick();
        n_cmp++; if (s_dc_v !== 1'b1) begin n_err++; $display("FAIL c1_dc_v: got %b expected 1", s_dc_v); end
        tick();
        n_cmp++; if (s_ptag !== 28'h80000) begin n_err++; $display("FAIL c2_ptag: got %h expected 80000", s_ptag); end
        tick();
        n_cmp++; if (s_resp_v !== 2'b01) begin n_err++; $display("FAIL c3_resp_v: got %b expected 01", s_resp_v); end
        n_cmp++; if (s_resp_data !== 64'hDEADBEEF) begin n_err++; $display("FAIL c3_data: got %h expected deadbeef", s_resp_data); end
        tick();
        n_cmp++; if (s_ready[0] !== 1'b1) begin n_err++; $display("FAIL c4_ready: got %b expected 1", s_ready[0]); end
    endtask

    task automatic test_back_to_back();
        int start, i0, r0, r1;
        apply_reset();
        start = grant_log.size(); r0 = n_resp0; r1 = n_resp1;
        for (int i = 0; i < 4; i++) begin
            new_op(1'b0, 28'h1000 + 28'(i), 64'h1111_0000 + 64'(i), i[0]);
            new_op(1'b1, 28'h2000 + 28'(i), 64'h2222_0000 + 64'(i), ~i[0]);
        end
        drain(100);
        n_cmp++;
        if (grant_log.size() - start != 8) begin
            n_err++; $display("FAIL b2b_grants: got %0d expected 8", grant_log.size() - start);
        end else begin
            for (int i = 0; i < 8; i++) begin
                i0 = i;
                n_cmp++;
                if (grant_log[start + i] !== (first_lane ^ i0[0])) begin
                    n_err++; $display("FAIL b2b_order[%0d]: got %b expected %b", i, grant_log[start + i], first_lane ^ i0[0]);
                end
            end
        end
        n_cmp++; if (n_resp0 - r0 != 4) begin n_err++; $display("FAIL b2b_resp0: got %0d expected 4", n_resp0 - r0); end
        n_cmp++; if (n_resp1 - r1 != 4) begin n_err++; $display("FAIL b2b_resp1: got %0d expected 4", n_resp1 - r1); end
    endtask

    task automatic test_miss_replay();
        int p0, is0, c;
        logic [7:0] seq_a;
        apply_reset();
        p0 = n_poison; is0 = n_issue;
        seq_a = next_seq;
        new_op(1'b0, 28'h0ABCD, 64'hA0A0_A0A0_0000_0001, 1'b1);
        new_op(1'b1, 28'h0BCDE, 64'hB0B0_B0B0_0000_0002, 1'b0);
        miss_seq = (first_lane == 1'b0) ? seq_a : seq_a + 8'd1;
        miss_armed = 1'b1;
        c = 0;
        while (n_poison == p0 && c < 20) begin tick(); c++; end
        n_cmp++; if (n_poison == p0) begin n_err++; $display("FAIL miss_no_poison: got none in %0d cycles", c); end
        dc_ready_i = 1'b0;
        repeat (3) begin
            tick();
            n_cmp++; if (s_dc_v !== 1'b0) begin n_err++; $display("FAIL miss_stall_dc_v: got %b expected 0", s_dc_v); end
        end
        dc_ready_i = 1'b1;
        drain(50);
        n_cmp++; if (n_poison - p0 != 1) begin n_err++; $display("FAIL miss_poison_count: got %0d expected 1", n_poison - p0); end
        n_cmp++; if (n_issue - is0 != 4) begin n_err++; $display("FAIL miss_issue_count: got %0d expected 4", n_issue - is0); end
    endtask

    task automatic test_stall();
        int is0;
        apply_reset();
        dc_ready_i = 1'b0;
        is0 = n_issue;
        new_op(1'b1, 28'h3333, 64'h5555_6666_7777_8888, 1'b1);
        tick();
        repeat (20) begin
            tick();
            n_cmp++; if (s_dc_v !== 1'b0) begin n_err++; $display("FAIL stall_dc_v: got %b expected 0", s_dc_v); end
            n_cmp++; if (s_ready[1] !== 1'b0) begin n_err++; $display("FAIL stall_ready1: got %b expected 0", s_ready[1]); end
        end
        dc_ready_i = 1'b1;
        drain(50);
        n_cmp++; if (n_issue - is0 != 1) begin n_err++; $display("FAIL stall_issue_count: got %0d expected 1", n_issue - is0); end
    endtask

    task automatic test_reset_in_dm();
        apply_reset();
        new_op(1'b0, 28'h4444, 64'hCAFE_F00D_0000_0004, 1'b1);
        repeat (3) tick();
        req_v_i = 2'b00;
        dc_v_i = 1'b1;
        dc_data_i = 64'hCAFE_F00D_0000_0004;
        reset_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        dc_v_i = 1'b0;
        dc_data_i = '0;
        #1;
        n_cmp++; if (req_ready_o !== 2'b11) begin n_err++; $display("FAIL flush_ready: got %b expected 11", req_ready_o); end
        n_cmp++; if (dc_v_o !== 1'b0) begin n_err++; $display("FAIL flush_dc_v: got %b expected 0", dc_v_o); end
        n_cmp++; if (dc_poison_o !== 1'b0) begin n_err++; $display("FAIL flush_poison: got %b expected 0", dc_poison_o); end
        n_cmp++; if (resp_v_o !== 2'b00) begin n_err++; $display("FAIL flush_resp_v: got %b expected 00", resp_v_o); end
        n_cmp++; if (dc_ptag_o !== '0) begin n_err++; $display("FAIL flush_ptag: got %h expected 0", dc_ptag_o); end
        n_cmp++; if (dc_uncached_o !== 1'b0) begin n_err++; $display("FAIL flush_uncached: got %b expected 0", dc_uncached_o); end
        m_tl_v = 1'b0; m_dm_v = 1'b0;
        exp_q0.delete();
        @(negedge clk);
        repeat (3) begin
            tick();
            n_cmp++; if (s_resp_v !== 2'b00) begin n_err++; $display("FAIL flush_late_resp: got %b expected 00", s_resp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_back_to_back();
        test_miss_replay();
        test_stall();
        test_reset_in_dm();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
